ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Consumes the byte stream (received_data / received_data_en) from the PS/2 transceiver. Decodes PS/2 Set-2 keyboard scan codes into make/break key events with an extended flag.
- Buffers events in a small FIFO with a valid/ready output. The step sequencer's key-mapping logic drains events at its own pace.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, min 2.
- TIMEOUT_CYCLES, 100000, CLOCK_50 cycles allowed between prefix bytes before the partial sequence is discarded (2 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  byte from PS/2 transceiver.
- rx_data_en  in  1  one-cycle strobe, rx_data valid.
- evt_ready  in  1  consumer accepts head event.
- evt_valid  out  1  FIFO non-empty.
- evt_code  out  8  scan code (prefixes stripped).
- evt_extended  out  1  code was preceded by E0.
- evt_released  out  1  1 = break (F0 seen), 0 = make.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in S_IDLE, timeout counter 0.
- Clocking: everything on posedge CLOCK_50. Bytes are sampled only when rx_data_en=1. rx_data_en is never asserted on consecutive cycles, but the block tolerates it.
- FSM states:
  - S_IDLE:
    - E0 -> S_EXT.
    - F0 -> S_BRK.
    - E1 -> S_PAUSE, skip count = 7.
    - AA, FA, FE, EE, 00, FF (status/ack bytes) -> ignored, stay.
    - Any other byte -> push {ext=0, rel=0, code}.
  - S_EXT:
    - F0 -> S_EXT_BRK.
    - 12 or 59 (fake shift) -> discard, S_IDLE.
    - Else -> push {1, 0, code}, S_IDLE.
  - S_BRK: any byte -> push {0, 1, code}, S_IDLE.
  - S_EXT_BRK:
    - 12 or 59 -> discard, S_IDLE.
    - Else -> push {1, 1, code}, S_IDLE.
  - S_PAUSE: each byte decrements the skip count. When the count reaches 0, push {1, 0, 0x77} once (Pause), then S_IDLE. Bytes are not validated.
- Timeout:
  - The counter runs in any non-IDLE state and restarts on each accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: return to S_IDLE, no event.
- Push latency: the event is written on the clock edge that samples its final byte. evt_valid rises on the following cycle (1-cycle latency).
- FIFO:
  - First-word fall-through; evt_* always reflect the head entry.
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push while full without pop: the event is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH. The count is kept in log2(FIFO_DEPTH)+1 bits.
- Overflow flag: overflow_clr has priority over a same-cycle set.
- Reset mid-sequence or with a non-empty FIFO: the FIFO is flushed and the FSM returns to idle immediately.

Optional Feature:
- Macro: TYPEMATIC_FILTER_EN.
- Defined:
  - Keeps a 512-bit held table indexed {extended, code}.
  - A make event for a key whose bit is already set is suppressed (not pushed); otherwise it is pushed and the bit is set.
  - A break event clears the bit and is always pushed.
  - Pause is never recorded.
  - The table is cleared on reset.
  - The table updates even when the push is dropped for overflow.
- Undefined: every typematic repeat make is pushed as a separate event. No table logic is synthesised.

Test Plan:
- Byte 1C, then F0 1C, evt_ready=1 -> two events {1C, ext0, rel0} then {1C, ext0, rel1}. Each evt_valid is high 1 cycle after the final byte.
- Bytes E0 75, then E0 F0 75 -> events {75, ext1, rel0} and {75, ext1, rel1}. E0 12 produces no event.
- evt_ready=0, send 5 makes (1C 1B 23 2B 34) with FIFO_DEPTH=4 -> FIFO holds 1C 1B 23 2B and overflow=1. Raise evt_ready -> drains in order. Pulse overflow_clr -> overflow=0.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {77, ext1, rel0}.
- Byte E0, then 100000 idle cycles, then byte 1C -> only {1C, ext0, rel0}, not extended. Assert reset mid-sequence -> no event, evt_valid=0.
- With TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C 1C -> events make, break, make. Without the macro -> 4 makes and 1 break.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//
// Turns the PS/2 Set-2 byte stream from the transceiver into key events
// (make/break, extended flag, bare scan code). Events are queued in a small
// first-word fall-through FIFO. The key-mapping logic drains that FIFO with a
// valid/ready handshake.
//
// Ports:
//   CLOCK_50      in   system clock, 50 MHz
//   reset         in   synchronous, active-high
//   rx_data       in   [7:0] byte from the PS/2 transceiver
//   rx_data_en    in   one-cycle strobe, rx_data valid
//   evt_ready     in   consumer accepts the head event
//   evt_valid     out  FIFO non-empty
//   evt_code      out  [7:0] scan code with prefixes stripped
//   evt_extended  out  code was preceded by E0
//   evt_released  out  1 = break (F0 seen), 0 = make
//   overflow      out  sticky; an event was dropped because the FIFO was full
//   overflow_clr  in   clears overflow (wins over a same-cycle set)
//
// Optional build macro:
//   TYPEMATIC_FILTER_EN  suppresses auto-repeat makes of a key that is already
//                        held down, using a 512-entry held table.

module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_extended,
  output logic       evt_released,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // FIFO entry layout: {extended, released, code}
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          cand_valid;
  logic          cand_ext;
  logic          cand_rel;
  logic [7:0]    cand_code;
  logic          push_valid;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [9:0]    head;

  // Decoder FSM. Any accepted byte restarts the prefix timeout; the timeout
  // only advances while a multi-byte sequence is partially received.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    cand_valid = 1'b0;
    cand_ext   = 1'b0;
    cand_rel   = 1'b0;
    cand_code  = rx_data;

    if (rx_data_en) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          case (rx_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
            end
            default: cand_valid = 1'b1;
          endcase
        end
        S_EXT: begin
          if (rx_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
            // E0 12 / E0 59 are fake shifts emitted around extended keys
            if (rx_data != 8'h12 && rx_data != 8'h59) begin
              cand_valid = 1'b1;
              cand_ext   = 1'b1;
            end
          end
        end
        S_BRK: begin
          state_d    = S_IDLE;
          cand_valid = 1'b1;
          cand_rel   = 1'b1;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (rx_data != 8'h12 && rx_data != 8'h59) begin
            cand_valid = 1'b1;
            cand_ext   = 1'b1;
            cand_rel   = 1'b1;
          end
        end
        S_PAUSE: begin
          // Pause sends E1 plus seven bytes; they are counted, not checked
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d    = S_IDLE;
            cand_valid = 1'b1;
            cand_ext   = 1'b1;
            cand_code  = 8'h77;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [511:0] held_q, held_d;
  logic [8:0]   held_idx;

  // A candidate produced while in S_PAUSE can only be the Pause event, which
  // is never tracked. The table updates whether or not the FIFO has room.
  always_comb begin
    held_d     = held_q;
    push_valid = cand_valid;
    held_idx   = {cand_ext, cand_code};
    if (cand_valid && state_q != S_PAUSE) begin
      if (cand_rel) begin
        held_d[held_idx] = 1'b0;
      end else if (held_q[held_idx]) begin
        push_valid = 1'b0;
      end else begin
        held_d[held_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end
`else
  always_comb begin
    push_valid = cand_valid;
  end
`endif

  // Event FIFO. A push into a full FIFO still succeeds when the head is popped
  // in the same cycle; only a push that truly has no room sets overflow.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    pop     = evt_valid && evt_ready;
    full    = (count_q == FIFO_FULL);
    push_ok = push_valid && (!full || pop);

    if (push_ok) begin
      mem_d[wr_ptr_q] = {cand_ext, cand_rel, cand_code};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end

    if (overflow_clr) begin
      overflow_d = 1'b0;
    end else if (push_valid && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      skip_q     <= '0;
      tmo_q      <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs are forced to zero while empty so stale entries never show
  assign head         = mem_q[rd_ptr_q];
  assign evt_valid    = (count_q != '0);
  assign evt_code     = evt_valid ? head[7:0] : 8'h00;
  assign evt_released = evt_valid & head[8];
  assign evt_extended = evt_valid & head[9];
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder
//
// Self-checking bench for ps2_scancode_decoder. A behavioural model decodes
// complete byte sequences from a queue and keeps the event FIFO as a queue;
// a compare process checks the DUT against it on every falling edge. Directed
// scenarios add literal expectations, then a randomized phase follows.

module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       clk;
  logic       reset;
  logic [7:0] rxData;
  logic       rxDataEn;
  logic       evtReady;
  logic       evtValid;
  logic [7:0] evtCode;
  logic       evtExtended;
  logic       evtReleased;
  logic       overflow;
  logic       overflowClr;

  int testsRun;
  int testsFailed;
  bit checkEn;
  int popCount;

  ps2_scancode_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .rx_data     (rxData),
    .rx_data_en  (rxDataEn),
    .evt_ready   (evtReady),
    .evt_valid   (evtValid),
    .evt_code    (evtCode),
    .evt_extended(evtExtended),
    .evt_released(evtReleased),
    .overflow    (overflow),
    .overflow_clr(overflowClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [9:0] modelQ [$];
  logic [7:0] seqQ [$];
  bit         modelOvf;
  longint     cyc;
  longint     lastByteCyc;
`ifdef TYPEMATIC_FILTER_EN
  bit         held [512];
`endif

  function automatic bit isStatus(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  // Model: sequences are collected whole and interpreted once they complete
  always @(posedge clk) begin : model
    logic [9:0] ent;
    logic [7:0] b;
    bit doPush, isPause, ext, rel, pop, full;
    doPush  = 1'b0;
    isPause = 1'b0;
    ent     = '0;
    if (reset) begin
      modelQ.delete();
      seqQ.delete();
      modelOvf = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      foreach (held[i]) held[i] = 1'b0;
`endif
    end else begin
      if (rxDataEn) begin
        if (seqQ.size() != 0 && (cyc - lastByteCyc) > TMO) seqQ.delete();
        lastByteCyc = cyc;
        b = rxData;
        seqQ.push_back(b);
        if (seqQ[0] == 8'hE1) begin
          if (seqQ.size() == 8) begin
            doPush  = 1'b1;
            isPause = 1'b1;
            ent     = {1'b1, 1'b0, 8'h77};
            seqQ.delete();
          end
        end else if (seqQ.size() == 1 && isStatus(b)) begin
          seqQ.delete();
        end else if ((seqQ.size() == 1 && (b == 8'hE0 || b == 8'hF0)) ||
                     (seqQ.size() == 2 && seqQ[0] == 8'hE0 && b == 8'hF0)) begin
          // prefix only, keep collecting
        end else begin
          ext = (seqQ[0] == 8'hE0);
          rel = (seqQ.size() >= 2) && (seqQ[seqQ.size()-2] == 8'hF0);
          if (!(ext && (b == 8'h12 || b == 8'h59))) begin
            doPush = 1'b1;
            ent    = {ext, rel, b};
          end
          seqQ.delete();
        end
      end
`ifdef TYPEMATIC_FILTER_EN
      if (doPush && !isPause) begin
        if (ent[8]) held[ent[9:8] == 2'b11 ? {1'b1, ent[7:0]} : {1'b0, ent[7:0]}] = 1'b0;
        else if (held[{ent[9], ent[7:0]}]) doPush = 1'b0;
        else held[{ent[9], ent[7:0]}] = 1'b1;
      end
`endif
      pop  = (modelQ.size() != 0) && evtReady;
      full = (modelQ.size() == DEPTH);
      if (pop) void'(modelQ.pop_front());
      if (overflowClr) modelOvf = 1'b0;
      if (doPush) begin
        if (!full || pop) modelQ.push_back(ent);
        else if (!overflowClr) modelOvf = 1'b1;
      end
    end
    cyc = cyc + 1;
  end

  always @(posedge clk) begin
    if (!reset && evtValid && evtReady) popCount <= popCount + 1;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    testsRun = testsRun + 1;
    if (actual !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("evt_valid", 8'(evtValid), 8'(modelQ.size() != 0));
      if (modelQ.size() != 0) begin
        checkOutput("evt_code", evtCode, modelQ[0][7:0]);
        checkOutput("evt_released", 8'(evtReleased), 8'(modelQ[0][8]));
        checkOutput("evt_extended", 8'(evtExtended), 8'(modelQ[0][9]));
      end
      checkOutput("overflow", 8'(overflow), 8'(modelOvf));
    end
  end

  // Called at a falling edge; returns at the falling edge after the byte was
  // sampled, when its event (if any) is already visible
  task automatic applyStimulus(input logic [7:0] b);
    rxData   = b;
    rxDataEn = 1'b1;
    @(negedge clk);
    rxDataEn = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] randomByte();
    logic [7:0] codes [7] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75, 8'h77};
    logic [7:0] stat  [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    case ($urandom_range(0, 11))
      0, 1: return 8'hE0;
      2, 3: return 8'hF0;
      4:    return 8'hE1;
      5:    return stat[$urandom_range(0, 5)];
      6:    return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      7, 8, 9: return codes[$urandom_range(0, 6)];
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] drainExp [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
    logic [7:0] pauseSeq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] typeSeq  [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    int popBase;
    int quietLeft;

    testsRun    = 0;
    testsFailed = 0;
    checkEn     = 1'b0;
    popCount    = 0;
    cyc         = 0;
    lastByteCyc = 0;
    modelOvf    = 1'b0;
    reset       = 1'b1;
    rxData      = 8'h00;
    rxDataEn    = 1'b0;
    evtReady    = 1'b0;
    overflowClr = 1'b0;

    idleCycles(3);
    reset   = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_valid", 8'(evtValid), 8'h00);
    checkOutput("reset_code", evtCode, 8'h00);
    checkOutput("reset_overflow", 8'(overflow), 8'h00);

    // Plain make then break, consumer always ready
    evtReady = 1'b1;
    applyStimulus(8'h1C);
    checkOutput("make_valid", 8'(evtValid), 8'h01);
    checkOutput("make_code", evtCode, 8'h1C);
    checkOutput("make_rel", 8'(evtReleased), 8'h00);
    applyStimulus(8'hF0);
    checkOutput("prefix_no_event", 8'(evtValid), 8'h00);
    applyStimulus(8'h1C);
    checkOutput("break_valid", 8'(evtValid), 8'h01);
    checkOutput("break_code", evtCode, 8'h1C);
    checkOutput("break_rel", 8'(evtReleased), 8'h01);

    // Extended make/break and a fake shift
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    checkOutput("ext_make_code", evtCode, 8'h75);
    checkOutput("ext_make_ext", 8'(evtExtended), 8'h01);
    checkOutput("ext_make_rel", 8'(evtReleased), 8'h00);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checkOutput("ext_break_ext", 8'(evtExtended), 8'h01);
    checkOutput("ext_break_rel", 8'(evtReleased), 8'h01);
    applyStimulus(8'hE0);
    applyStimulus(8'h12);
    checkOutput("fake_shift_none", 8'(evtValid), 8'h00);

    // Fill past capacity, then drain in order and clear the sticky flag
    evtReady = 1'b0;
    applyStimulus(8'h1C);
    applyStimulus(8'h1B);
    applyStimulus(8'h23);
    applyStimulus(8'h2B);
    applyStimulus(8'h34);
    checkOutput("ovf_set", 8'(overflow), 8'h01);
    evtReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_code", evtCode, drainExp[i]);
      @(negedge clk);
    end
    checkOutput("drain_empty", 8'(evtValid), 8'h00);
    overflowClr = 1'b1;
    @(negedge clk);
    overflowClr = 1'b0;
    checkOutput("ovf_clr", 8'(overflow), 8'h00);

    // Pause sequence yields exactly one event
    evtReady = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(pauseSeq[i]);
    checkOutput("pause_code", evtCode, 8'h77);
    checkOutput("pause_ext", 8'(evtExtended), 8'h01);
    checkOutput("pause_rel", 8'(evtReleased), 8'h00);
    evtReady = 1'b1;
    @(negedge clk);
    checkOutput("pause_single", 8'(evtValid), 8'h00);

    // Timeout discards a dangling E0
    evtReady = 1'b0;
    applyStimulus(8'hE0);
    idleCycles(TMO + 2);
    applyStimulus(8'h1C);
    checkOutput("tmo_code", evtCode, 8'h1C);
    checkOutput("tmo_ext", 8'(evtExtended), 8'h00);
    evtReady = 1'b1;
    idleCycles(2);

    // Reset mid-sequence with a non-empty FIFO
    evtReady = 1'b0;
    applyStimulus(8'h1C);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_flush", 8'(evtValid), 8'h00);
    applyStimulus(8'h1C);
    checkOutput("rst_idle_ext", 8'(evtExtended), 8'h00);
    checkOutput("rst_idle_rel", 8'(evtReleased), 8'h00);
    evtReady = 1'b1;
    idleCycles(2);

    // Typematic repeats
    popBase = popCount;
    for (int i = 0; i < 6; i++) applyStimulus(typeSeq[i]);
    idleCycles(3);
`ifdef TYPEMATIC_FILTER_EN
    checkOutput("typematic_count", 8'(popCount - popBase), 8'd3);
`else
    checkOutput("typematic_count", 8'(popCount - popBase), 8'd5);
`endif

    // Randomized traffic
    quietLeft = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 899) == 0) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(0, 149) == 0) quietLeft = $urandom_range(TMO - 5, TMO + 5);
      if (quietLeft > 0) begin
        quietLeft = quietLeft - 1;
        rxDataEn  = 1'b0;
      end else begin
        rxDataEn = ($urandom_range(0, 2) == 0);
      end
      rxData      = randomByte();
      evtReady    = ($urandom_range(0, 3) != 0);
      overflowClr = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    reset       = 1'b0;
    rxDataEn    = 1'b0;
    overflowClr = 1'b0;
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
